// File: rtl/video_in_store_burst_if.sv
// Bundles the pixel-FIFO, frame-address, Wishbone write-master and interrupt
// signals of video_in_store_burst; master is the store engine, slave is its surroundings.
interface video_in_store_burst_if #(
    parameter int CNT_W = 10
);
    logic [31:0]      frame_addr;
    logic             frame_addr_we;
    logic [31:0]      fifo_data;
    logic [CNT_W-1:0] fifo_count;
    logic             fifo_rd;
    logic             p_wb_CYC_O;
    logic             p_wb_STB_O;
    logic             p_wb_LOCK_O;
    logic             p_wb_WE_O;
    logic [3:0]       p_wb_SEL_O;
    logic [31:0]      p_wb_ADR_O;
    logic [31:0]      p_wb_DAT_O;
    logic             p_wb_ACK_I;
    logic             p_wb_ERR_I;
    logic             irq_frame;
    logic             irq_err;
    logic             busy;

    modport master (
        input  frame_addr, frame_addr_we, fifo_data, fifo_count, p_wb_ACK_I, p_wb_ERR_I,
        output fifo_rd, p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O,
               p_wb_ADR_O, p_wb_DAT_O, irq_frame, irq_err, busy
    );

    modport slave (
        output frame_addr, frame_addr_we, fifo_data, fifo_count, p_wb_ACK_I, p_wb_ERR_I,
        input  fifo_rd, p_wb_CYC_O, p_wb_STB_O, p_wb_LOCK_O, p_wb_WE_O, p_wb_SEL_O,
               p_wb_ADR_O, p_wb_DAT_O, irq_frame, irq_err, busy
    );
endinterface

// File: rtl/video_in_store_burst.sv
// Wishbone burst write master storing FIFO video words into a double-buffered frame buffer.
// A burst starts the cycle after enough words are queued; one word per ACK, the slave stalls via ACK.
module video_in_store_burst #(
    parameter int P_WIDTH      = 640,
    parameter int P_HEIGHT     = 480,
    parameter int PIX_PER_WORD = 4,
    parameter int BURST_LEN    = 16,
    parameter int CNT_W        = 10
) (
    input  logic                   clk,
    input  logic                   RST,
    video_in_store_burst_if.master bus
);
    localparam int FRAME_WORDS = P_WIDTH * P_HEIGHT / PIX_PER_WORD;
    localparam int WC_W        = $clog2(FRAME_WORDS + 1);
    localparam int BL_W        = $clog2(BURST_LEN + 1);

    typedef enum logic [1:0] {IDLE, WAIT_DATA, BURST, DONE} state_t;

    state_t           state;
    logic [31:0]      pending_addr;
    logic             pending_valid;
    logic [31:0]      active_base;
    logic [31:0]      adr;
    logic [WC_W-1:0]  word_cnt;
    logic [BL_W-1:0]  beats_left;
    logic             cyc;
    logic             irq_frame;
    logic             irq_err;
    logic [CNT_W-1:0] fifo_cnt;
    logic [31:0]      words_left;
    logic [31:0]      burst_n;
    logic             ack;
    logic             err;

    assign fifo_cnt   = bus.fifo_count;
    assign words_left = 32'(FRAME_WORDS) - 32'(word_cnt);
    assign burst_n    = (words_left < 32'(BURST_LEN)) ? words_left : 32'(BURST_LEN);

    // ERR takes priority over a simultaneous ACK; both are ignored outside a strobe.
    assign err = cyc & bus.p_wb_ERR_I;
    assign ack = cyc & bus.p_wb_ACK_I & ~bus.p_wb_ERR_I;

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            pending_addr  <= '0;
            pending_valid <= 1'b0;
            active_base   <= '0;
            adr           <= '0;
            word_cnt      <= '0;
            beats_left    <= '0;
            cyc           <= 1'b0;
            irq_frame     <= 1'b0;
            irq_err       <= 1'b0;
        end else begin
            irq_frame <= 1'b0;
            irq_err   <= 1'b0;
            if (bus.frame_addr_we) begin
                pending_addr  <= bus.frame_addr;
                pending_valid <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (pending_valid) begin
                        active_base <= pending_addr;
                        if (!bus.frame_addr_we) pending_valid <= 1'b0;
                        word_cnt <= '0;
                        state    <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (32'(fifo_cnt) >= burst_n) begin
                        cyc        <= 1'b1;
                        adr        <= active_base + (32'(word_cnt) << 2);
                        beats_left <= BL_W'(burst_n);
                        state      <= BURST;
                    end
                end
                BURST: begin
                    if (err) begin
                        cyc     <= 1'b0;
                        irq_err <= 1'b1;
                        state   <= IDLE;
                    end else if (ack) begin
                        word_cnt   <= word_cnt + 1'b1;
                        adr        <= adr + 32'd4;
                        beats_left <= beats_left - 1'b1;
                        if (beats_left == BL_W'(1)) begin
                            cyc <= 1'b0;
                            if (32'(word_cnt) + 32'd1 == 32'(FRAME_WORDS)) begin
                                irq_frame <= 1'b1;
                                state     <= DONE;
                            end else begin
                                state <= WAIT_DATA;
                            end
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.p_wb_CYC_O  = cyc;
    assign bus.p_wb_STB_O  = cyc;
    assign bus.p_wb_LOCK_O = cyc;
    assign bus.p_wb_WE_O   = cyc;
    assign bus.p_wb_SEL_O  = 4'hF;
    assign bus.p_wb_ADR_O  = adr;
    assign bus.p_wb_DAT_O  = cyc ? bus.fifo_data : 32'd0;
    assign bus.fifo_rd     = ack;
    assign bus.irq_frame   = irq_frame;
    assign bus.irq_err     = irq_err;
    assign bus.busy        = (state != IDLE);
endmodule

// File: tb/tb_video_in_store_burst.sv
// Bench for video_in_store_burst: 8x2 frame, 4 pixels/word (4 words/frame), bursts of up to 3.
module tb_video_in_store_burst;
    localparam int CNT_W = 10;

    logic clk = 1'b0;
    logic RST = 1'b0;
    always #5 clk = ~clk;

    video_in_store_burst_if #(.CNT_W(CNT_W)) vif();

    video_in_store_burst #(
        .P_WIDTH(8), .P_HEIGHT(2), .PIX_PER_WORD(4), .BURST_LEN(3), .CNT_W(CNT_W)
    ) dut (
        .clk(clk),
        .RST(RST),
        .bus(vif)
    );

    typedef struct {
        logic [31:0] base;
        int          ws;
        int          prefill;
        int          gap;
        int          err_beat;
        int          exp_beats;
        int          exp_bursts;
        int          exp_len0;
        int          exp_rise0;
        int          exp_irqf;
        int          exp_irqe;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fifo_q[$];
    logic [31:0] next_word = 32'hCAFE_0000;
    int ws, err_beat, gap, gap_cnt, to_push, wcnt, beat_idx, cyc_n;
    logic        addr_req;
    logic [31:0] addr_val;

    logic [31:0] beat_adr[$];
    logic [31:0] beat_dat[$];
    int burst_len[$];
    int rise_cnt[$];
    int rise_cyc[$];
    int irq_cyc[$];
    int irqf, irqe, viol, cur_len, busy_cnt;
    logic        prev_cyc, prev_stb, prev_term;
    logic [31:0] prev_adr, prev_dat;

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_word();
        fifo_q.push_back(next_word);
        next_word = next_word + 32'd1;
    endtask

    task automatic refresh_fifo();
        vif.fifo_data  = (fifo_q.size() > 0) ? fifo_q[0] : 32'd0;
        vif.fifo_count = CNT_W'(fifo_q.size());
    endtask

    task automatic clear_mon();
        beat_adr.delete(); beat_dat.delete(); burst_len.delete();
        rise_cnt.delete(); rise_cyc.delete(); irq_cyc.delete();
        irqf = 0; irqe = 0; viol = 0; cur_len = 0; busy_cnt = 0;
        prev_cyc = 1'b0; prev_stb = 1'b0; prev_term = 1'b0;
        prev_adr = '0; prev_dat = '0;
    endtask

    // One clock: observe at the falling edge, then update bench FIFO/slave just after the rising edge.
    task automatic step();
        logic pop_now, exp_pop;
        logic [31:0] tmp;
        @(negedge clk);
        pop_now = vif.fifo_rd;
        exp_pop = vif.p_wb_STB_O & vif.p_wb_ACK_I & ~vif.p_wb_ERR_I;
        if (pop_now !== exp_pop) viol++;
        if (pop_now && vif.fifo_count == '0) viol++;
        if (vif.p_wb_LOCK_O !== vif.p_wb_CYC_O || vif.p_wb_WE_O !== vif.p_wb_CYC_O ||
            vif.p_wb_STB_O !== vif.p_wb_CYC_O) viol++;
        if (vif.p_wb_SEL_O !== 4'hF) viol++;
        if (!vif.p_wb_STB_O && vif.p_wb_DAT_O !== 32'd0) viol++;
        if (vif.p_wb_STB_O && vif.p_wb_DAT_O !== vif.fifo_data) viol++;
        if (prev_stb && !prev_term && vif.p_wb_STB_O &&
            (vif.p_wb_ADR_O !== prev_adr || vif.p_wb_DAT_O !== prev_dat)) viol++;
        if (vif.p_wb_CYC_O && !prev_cyc) begin
            rise_cnt.push_back(int'(vif.fifo_count));
            rise_cyc.push_back(cyc_n);
            cur_len = 0;
        end
        if (pop_now) begin
            beat_adr.push_back(vif.p_wb_ADR_O);
            beat_dat.push_back(vif.p_wb_DAT_O);
            cur_len++;
        end
        if (!vif.p_wb_CYC_O && prev_cyc) burst_len.push_back(cur_len);
        if (vif.irq_frame) begin irqf++; irq_cyc.push_back(cyc_n); end
        if (vif.irq_err) irqe++;
        if (vif.busy) busy_cnt++;
        prev_cyc  = vif.p_wb_CYC_O;
        prev_stb  = vif.p_wb_STB_O;
        prev_term = vif.p_wb_STB_O & (vif.p_wb_ACK_I | vif.p_wb_ERR_I);
        prev_adr  = vif.p_wb_ADR_O;
        prev_dat  = vif.p_wb_DAT_O;
        cyc_n++;

        @(posedge clk); #1;
        if (pop_now && fifo_q.size() > 0) tmp = fifo_q.pop_front();
        if (gap > 0 && to_push > 0) begin
            gap_cnt++;
            if (gap_cnt >= gap) begin gap_cnt = 0; push_word(); to_push--; end
        end
        vif.frame_addr_we = 1'b0;
        if (addr_req) begin
            vif.frame_addr    = addr_val;
            vif.frame_addr_we = 1'b1;
            addr_req          = 1'b0;
        end
        vif.p_wb_ACK_I = 1'b0;
        vif.p_wb_ERR_I = 1'b0;
        if (vif.p_wb_STB_O) begin
            if (wcnt >= ws) begin
                wcnt = 0;
                vif.p_wb_ACK_I = 1'b1;
                if (beat_idx == err_beat) vif.p_wb_ERR_I = 1'b1;
                beat_idx++;
            end else begin
                wcnt++;
            end
        end else begin
            wcnt = 0;
        end
        refresh_fifo();
    endtask

    task automatic run_until(int target, int max_cyc, string name);
        int n = 0;
        while ((irqf + irqe) < target && n < max_cyc) begin step(); n++; end
        check(name, 32'((irqf + irqe) >= target), 32'd1);
    endtask

    task automatic setup_scn(int ws_i, int err_i, int gap_i);
        fifo_q.delete(); clear_mon();
        ws = ws_i; err_beat = err_i; gap = gap_i;
        gap_cnt = 0; beat_idx = 0; wcnt = 0; to_push = 0;
    endtask

    vec_t vecs[5];
    logic [31:0] word0;
    int n;

    initial begin
        vecs[0] = '{32'h0000_1000, 0, 4, 0, -1, 4, 2, 3, 4, 1, 0};
        vecs[1] = '{32'h0000_3000, 0, 0, 4, -1, 4, 2, 3, 3, 1, 0};
        vecs[2] = '{32'h0000_5000, 2, 4, 0, -1, 4, 2, 3, 4, 1, 0};
        vecs[3] = '{32'h0000_7000, 0, 4, 0,  1, 1, 1, 1, 4, 0, 1};
        vecs[4] = '{32'hFFFF_FFF8, 0, 4, 0, -1, 4, 2, 3, 4, 1, 0};

        cyc_n = 0; addr_req = 1'b0; addr_val = '0;
        vif.frame_addr = '0; vif.frame_addr_we = 1'b0;
        vif.p_wb_ACK_I = 1'b0; vif.p_wb_ERR_I = 1'b0;
        setup_scn(0, -1, 0);
        refresh_fifo();

        #2 RST = 1'b1;
        #1;
        check("rst_cyc",   32'(vif.p_wb_CYC_O), 32'd0);
        check("rst_stb",   32'(vif.p_wb_STB_O), 32'd0);
        check("rst_sel",   32'(vif.p_wb_SEL_O), 32'hF);
        check("rst_adr",   vif.p_wb_ADR_O, 32'd0);
        check("rst_rd",    32'(vif.fifo_rd), 32'd0);
        check("rst_busy",  32'(vif.busy), 32'd0);
        check("rst_irq",   32'({vif.irq_frame, vif.irq_err}), 32'd0);
        repeat (2) @(posedge clk);
        #1 RST = 1'b0;

        // No address written: engine must stay idle.
        repeat (10) step();
        check("idle_bursts", rise_cyc.size(), 32'd0);
        check("idle_busy", busy_cnt, 32'd0);

        for (int r = 0; r < 5; r++) begin
            setup_scn(vecs[r].ws, vecs[r].err_beat, vecs[r].gap);
            word0 = next_word;
            repeat (vecs[r].prefill) push_word();
            to_push = 4 - vecs[r].prefill;
            refresh_fifo();
            addr_val = vecs[r].base; addr_req = 1'b1;
            run_until(1, 400, $sformatf("r%0d_timeout", r));
            repeat (6) step();
            check($sformatf("r%0d_beats", r), beat_adr.size(), vecs[r].exp_beats);
            check($sformatf("r%0d_bursts", r), burst_len.size(), vecs[r].exp_bursts);
            if (burst_len.size() > 0) check($sformatf("r%0d_len0", r), burst_len[0], vecs[r].exp_len0);
            if (rise_cnt.size() > 0) check($sformatf("r%0d_rise_cnt", r), rise_cnt[0], vecs[r].exp_rise0);
            check($sformatf("r%0d_irq_frame", r), irqf, vecs[r].exp_irqf);
            check($sformatf("r%0d_irq_err", r), irqe, vecs[r].exp_irqe);
            check($sformatf("r%0d_fifo_left", r), fifo_q.size(), 4 - vecs[r].exp_beats);
            check($sformatf("r%0d_protocol", r), viol, 32'd0);
            check($sformatf("r%0d_busy_end", r), 32'(vif.busy), 32'd0);
            for (int k = 0; k < vecs[r].exp_beats; k++) begin
                if (k < beat_adr.size()) begin
                    check($sformatf("r%0d_adr%0d", r, k), beat_adr[k], vecs[r].base + 32'(4 * k));
                    check($sformatf("r%0d_dat%0d", r, k), beat_dat[k], word0 + 32'(k));
                end
            end
        end

        // Second address written mid-frame: next frame follows straight after irq_frame.
        setup_scn(0, -1, 0);
        word0 = next_word;
        repeat (8) push_word();
        refresh_fifo();
        addr_val = 32'h0000_1000; addr_req = 1'b1;
        n = 0;
        while (rise_cyc.size() == 0 && n < 50) begin step(); n++; end
        addr_val = 32'h0000_2000; addr_req = 1'b1;
        run_until(2, 400, "b2b_timeout");
        repeat (6) step();
        check("b2b_beats", beat_adr.size(), 32'd8);
        check("b2b_irq_frame", irqf, 32'd2);
        check("b2b_protocol", viol, 32'd0);
        if (beat_adr.size() == 8) begin
            check("b2b_adr3", beat_adr[3], 32'h0000_100C);
            check("b2b_adr4", beat_adr[4], 32'h0000_2000);
            check("b2b_adr7", beat_adr[7], 32'h0000_200C);
            check("b2b_dat7", beat_dat[7], word0 + 32'd7);
        end
        if (irq_cyc.size() >= 1 && rise_cyc.size() >= 3)
            check("b2b_restart_gap", rise_cyc[2] - irq_cyc[0], 32'd3);
        clear_mon();
        repeat (10) step();
        check("b2b_idle_busy", busy_cnt, 32'd0);

        // Reset in the middle of a stalled beat, with a second address pending.
        setup_scn(2, -1, 0);
        word0 = next_word;
        repeat (4) push_word();
        refresh_fifo();
        addr_val = 32'h0000_9000; addr_req = 1'b1;
        n = 0;
        while (!vif.p_wb_CYC_O && n < 50) begin step(); n++; end
        addr_val = 32'h0000_A000; addr_req = 1'b1;
        step();
        step();
        #2;
        check("rst_pre_rd", 32'(vif.fifo_rd), 32'd1);
        RST = 1'b1;
        #1;
        check("rst_mid_cyc",  32'(vif.p_wb_CYC_O), 32'd0);
        check("rst_mid_stb",  32'(vif.p_wb_STB_O), 32'd0);
        check("rst_mid_lock", 32'(vif.p_wb_LOCK_O), 32'd0);
        check("rst_mid_rd",   32'(vif.fifo_rd), 32'd0);
        vif.p_wb_ACK_I = 1'b0; vif.p_wb_ERR_I = 1'b0; wcnt = 0;
        @(posedge clk);
        #1 RST = 1'b0;
        clear_mon();
        repeat (10) step();
        check("rst_pending_lost", rise_cyc.size(), 32'd0);
        check("rst_irq_none", irqf + irqe, 32'd0);
        check("rst_fifo_kept", fifo_q.size(), 32'd4);
        ws = 0; beat_idx = 0;
        addr_val = 32'h0000_B000; addr_req = 1'b1;
        run_until(1, 400, "rst_restart_timeout");
        repeat (6) step();
        check("rst_restart_beats", beat_adr.size(), 32'd4);
        check("rst_restart_irq", irqf, 32'd1);
        if (beat_adr.size() > 0) begin
            check("rst_restart_adr0", beat_adr[0], 32'h0000_B000);
            check("rst_restart_dat0", beat_dat[0], word0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
